// File: rtl/alu32_serial_addsub_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial add/sub unit.
package alu32_serial_addsub_pkg;

    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned NIBBLES_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu32_serial_addsub_if.sv
// Request/response bundle between a requester (master) and the serial adder (slave).
interface alu32_serial_addsub_if
    import alu32_serial_addsub_pkg::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEF
);
    localparam int unsigned DATA_W = NIBBLE_W * NIBBLES;

    logic              start;
    logic              op_sub;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              c;
    logic              n;
    logic              z;
    logic              v;

    modport master (
        output start, op_sub, a, b,
        input  busy, done, result, c, n, z, v
    );

    modport slave (
        input  start, op_sub, a, b,
        output busy, done, result, c, n, z, v
    );

endinterface

// File: rtl/alu32_serial_addsub_cla4_slice.sv
// 4-bit carry-lookahead adder slice; purely combinational, reused every RUN cycle.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a | b;

    // Lookahead carries, each expressed directly from g/p and the slice carry-in.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s  = a ^ b ^ w_c[3:0];
    assign c3 = w_c[3];
    assign c4 = w_c[4];

endmodule

// File: rtl/alu32_serial_addsub.sv
// Nibble-serial 32-bit adder/subtractor: one 4-bit CLA slice per cycle, NZCV flags on completion.
module alu32_serial_addsub
    import alu32_serial_addsub_pkg::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu32_serial_addsub_if.slave  bus
);
    localparam int unsigned DATA_W = NIBBLE_W * NIBBLES;
    localparam int unsigned CNT_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned IDX_W  = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_carry;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_result;
    logic                r_c;
    logic                r_n;
    logic                r_z;
    logic                r_v;

    logic                w_accept;
    logic                w_last;
    logic [IDX_W-1:0]    w_idx;
    logic [3:0]          w_sum;
    logic                w_c3;
    logic                w_c4;
    logic [DATA_W-1:0]   w_result_nxt;

    // Start is only honoured when no operation is in flight.
    assign w_accept = bus.start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);
    assign w_idx    = {r_cnt, 2'b00};

    cla4_slice u_slice (
        .a  (r_a[w_idx +: NIBBLE_W]),
        .b  (r_b[w_idx +: NIBBLE_W]),
        .ci (r_carry),
        .s  (w_sum),
        .c3 (w_c3),
        .c4 (w_c4)
    );

    // Result with the current nibble merged in; also feeds the final N/Z flags.
    always_comb begin
        w_result_nxt = r_result;
        if (r_state == RUN) begin
            w_result_nxt[w_idx +: NIBBLE_W] = w_sum;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE falls straight back into RUN on a back-to-back start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_last)   w_state_nxt = DONE;
            DONE:    w_state_nxt = w_accept ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation and flag capture on the last nibble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b1;
            r_v      <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b ^ {DATA_W{bus.op_sub}};
            r_carry <= bus.op_sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_result <= w_result_nxt;
            r_carry  <= w_c4;
            r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_last) begin
                r_c <= w_c4;
                r_v <= w_c3 ^ w_c4;
                r_n <= w_result_nxt[DATA_W-1];
                r_z <= (w_result_nxt == '0);
            end
        end
    end

    assign bus.busy   = (r_state == RUN);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.c      = r_c;
    assign bus.n      = r_n;
    assign bus.z      = r_z;
    assign bus.v      = r_v;

endmodule

// File: doc/alu32_serial_addsub.md
ALU32_SERIAL_ADDSUB -- requirements
Module: alu32_serial_addsub

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named per codebase convention (clk, reset_n).
REQ-002 Parameter: NIBBLES, 8, number of 4-bit slices processed, one per cycle; data width is 4*NIBBLES (32).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a new operation; sampled on rising clk.
REQ-006 op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 a  input  32  operand A; sampled with start.
REQ-008 b  input  32  operand B; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse: result and flags valid.
REQ-011 result  output  32  sum/difference; held until the next accepted start.
REQ-012 c  output  1  carry out of bit 31 (subtract: 1 = no borrow).
REQ-013 n  output  1  result[31].
REQ-014 z  output  1  result == 0.
REQ-015 v  output  1  signed overflow = carry into bit 31 XOR carry out of bit 31.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; busy = (state == RUN); done = (state == DONE).
REQ-017 start is accepted only when busy = 0, i.e. in IDLE or DONE; start during RUN SHALL be ignored, with no effect on the operands or the counter.
REQ-018 On acceptance: latch A = a, B = b XOR {32{op_sub}}, carry register = op_sub, nibble counter = 0, next state RUN.
REQ-019 In RUN, each cycle SHALL add nibble[cnt] of A and B with the carry register using 4-bit lookahead carries (g = a&b, p = a|b, c1..c4 from the carry register).
REQ-020 Each RUN cycle SHALL write sum bits into result[4*cnt+3:4*cnt], load the carry register with c4 and increment cnt.
REQ-021 When cnt == NIBBLES-1, the RUN cycle SHALL also capture c4 into c and c3 XOR c4 into v, then move to DONE.
REQ-022 Latency: start accepted at edge T; done is high for the cycle after edge T+8, and result/flags are stable from that cycle.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE unless start is accepted in that cycle (back-to-back), in which case the next state is RUN.
REQ-024 n and z SHALL be derived from the final result and hold with it.
REQ-025 Wrap-around: modulo-2^32 arithmetic; 0xFFFFFFFF+1 yields 0 with c = 1.

Reset
REQ-026 While reset_n = 0: state = IDLE, cnt = 0, carry register = 0, result = 0, c = n = v = 0, z = 1, busy = done = 0; all asynchronous.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse follows reset deassertion.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), NIBBLE_W = 4 and the default NIBBLES.
REQ-029 A single combinational sub-module cla4_slice (inputs a[3:0], b[3:0], ci; outputs s[3:0], c3, c4) SHALL be instantiated once and reused every cycle.
REQ-030 Expected size: 120-250 lines of RTL including the slice.

Verification
REQ-031 add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, n=1, v=1, c=0, z=0, done at 9th cycle after accept.
REQ-032 sub 0x00000005 - 0x00000005 -> result 0, z=1, c=1, v=0, n=0.
REQ-033 sub 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, c=0, n=1, v=0; add 0xFFFFFFFF + 1 -> 0, c=1, z=1.
REQ-034 start pulsed with new operands at RUN cycle 3 -> ignored; the first operation's result is unchanged.
REQ-035 reset_n low at RUN cycle 4 -> outputs at reset values immediately, no done afterward; start held high in DONE -> second operation runs back-to-back with correct result.
